// File: rtl/alu32_arbiter.sv
// Two-requester front end sharing one 32-bit ALU: combinational grant, one operand
// stage, one registered result stage with a per-requester done pulse.

`ifndef ALU_ADD
`define ALU_AND  3'b000
`define ALU_OR   3'b001
`define ALU_ADD  3'b010
`define ALU_XOR  3'b011
`define ALU_NOR  3'b100
`define ALU_SLTU 3'b101
`define ALU_SUB  3'b110
`define ALU_SLT  3'b111
`endif

module alu32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  control,
  output logic [31:0] result,
  output logic        overflow,
  output logic        zero,
  output logic        negative
);

  logic [31:0] w_sum;
  logic [31:0] w_diff;

  assign w_sum  = a + b;
  assign w_diff = a - b;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (control)
      `ALU_AND:  result = a & b;
      `ALU_OR:   result = a | b;
      `ALU_XOR:  result = a ^ b;
      `ALU_NOR:  result = ~(a | b);
      `ALU_SLTU: result = {31'b0, (a < b)};
      `ALU_SLT:  result = {31'b0, ($signed(a) < $signed(b))};
      `ALU_ADD: begin
        result   = w_sum;
        overflow = (a[31] == b[31]) && (w_sum[31] != a[31]);
      end
      `ALU_SUB: begin
        result   = w_diff;
        overflow = (a[31] != b[31]) && (w_diff[31] != a[31]);
      end
      default: result = '0;
    endcase
  end

  assign zero     = (result == 32'd0);
  assign negative = result[31];

endmodule

module alu32_arbiter #(
  parameter int FIXED_PRI = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] A0,
  input  logic [31:0] B0,
  input  logic [31:0] A1,
  input  logic [31:0] B1,
  input  logic [2:0]  control0,
  input  logic [2:0]  control1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] out,
  output logic        overflow,
  output logic        zero,
  output logic        negative
);

  typedef enum logic {OWNER_0 = 1'b0, OWNER_1 = 1'b1} owner_e;

  // Arbitration state: which requester won the most recent accept.
  owner_e      r_last;

  // Operand stage
  logic        r_stage_valid;
  owner_e      r_owner;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [2:0]  r_ctrl;

  // Result stage
  logic [31:0] r_out;
  logic        r_overflow;
  logic        r_zero;
  logic        r_negative;
  logic        r_done0;
  logic        r_done1;

  logic        w_pick0;
  logic        w_gnt0;
  logic        w_gnt1;
  logic [31:0] w_result;
  logic        w_overflow;
  logic        w_zero;
  logic        w_negative;

  // On contention requester 0 wins if priority is fixed or requester 1 went last.
  assign w_pick0 = (FIXED_PRI != 0) || (r_last == OWNER_1);
  assign w_gnt0  = reset && req0 && (!req1 || w_pick0);
  assign w_gnt1  = reset && req1 && (!req0 || !w_pick0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last        <= OWNER_1;
      r_stage_valid <= 1'b0;
    end else begin
      r_stage_valid <= w_gnt0 || w_gnt1;
      if (w_gnt0)      r_last <= OWNER_0;
      else if (w_gnt1) r_last <= OWNER_1;
    end
  end

  // NOTE: operand registers carry no reset; r_stage_valid alone qualifies them,
  // and grants are already held low during reset.
  always_ff @(posedge clk) begin
    if (w_gnt0) begin
      r_a     <= A0;
      r_b     <= B0;
      r_ctrl  <= control0;
      r_owner <= OWNER_0;
    end else if (w_gnt1) begin
      r_a     <= A1;
      r_b     <= B1;
      r_ctrl  <= control1;
      r_owner <= OWNER_1;
    end
  end

  alu32 u_alu (
    .a        (r_a),
    .b        (r_b),
    .control  (r_ctrl),
    .result   (w_result),
    .overflow (w_overflow),
    .zero     (w_zero),
    .negative (w_negative)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out      <= '0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
    end else begin
      r_done0 <= r_stage_valid && (r_owner == OWNER_0);
      r_done1 <= r_stage_valid && (r_owner == OWNER_1);
      if (r_stage_valid) begin
        r_out      <= w_result;
        r_overflow <= w_overflow;
        r_zero     <= w_zero;
        r_negative <= w_negative;
      end
    end
  end

  assign gnt0     = w_gnt0;
  assign gnt1     = w_gnt1;
  assign done0    = r_done0;
  assign done1    = r_done1;
  assign out      = r_out;
  assign overflow = r_overflow;
  assign zero     = r_zero;
  assign negative = r_negative;

endmodule
